// File: rtl/mips16_md_pkg.sv
// Shared definitions for the mips16 multiply/divide unit: op encodings,
// datapath width, iteration count, FSM state type and a magnitude helper.
package mips16_md_pkg;

   localparam int MD_WIDTH = 16;
   localparam int MD_ITER  = 16;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_DONE
   } mdState_t;

   // Two's-complement magnitude; 16'h8000 maps to itself and is then
   // treated as an unsigned 32768 by the datapath.
   function automatic logic [MD_WIDTH-1:0] mdMagnitude(input logic [MD_WIDTH-1:0] value);
      return value[MD_WIDTH-1] ? ('0 - value) : value;
   endfunction

endpackage

// File: rtl/mips16_md_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: conditional add of the multiplicand, then a right shift of the
// {acc,q} product pair. Divide: left shift of {rem,quot}, trial subtract,
// quotient bit set when the subtract does not borrow.
module mips16_md_step #(
   parameter int W = 16
) (
   input  logic         i_isDiv,
   input  logic [W-1:0] i_acc,
   input  logic [W-1:0] i_q,
   input  logic [W-1:0] i_m,
   output logic [W-1:0] o_acc,
   output logic [W-1:0] o_q
);

   logic [W:0]   w_sum;
   logic [W:0]   w_shift;
   logic [W-1:0] w_diff;
   logic         w_fits;

   // Both iteration flavours are computed; the mode picks which one advances.
   // When the trial subtract fits, the true difference is below the divisor,
   // so the low W bits of the subtraction are exact.
   always_comb begin
      w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);
      w_shift = {i_acc, i_q[W-1]};
      w_fits  = (w_shift >= {1'b0, i_m});
      w_diff  = w_shift[W-1:0] - i_m;
      if (i_isDiv) begin
         if (w_fits) begin
            o_acc = w_diff;
            o_q   = {i_q[W-2:0], 1'b1};
         end else begin
            o_acc = w_shift[W-1:0];
            o_q   = {i_q[W-2:0], 1'b0};
         end
      end else begin
         o_acc = w_sum[W:1];
         o_q   = {w_sum[0], i_q[W-1:1]};
      end
   end

endmodule

// File: rtl/mips16_mult_div.sv
// Iterative 16-bit multiply/divide unit owning HI/LO for the mips16_sc core.
// Define MIPS16_MD_SIGNED_EN to enable signed mult/div (ops 00/10); without
// it those ops run unsigned, identical to multu/divu.
module mips16_mult_div
   import mips16_md_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_lo_sl,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             ready,
   output logic             stall,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(MD_ITER);

   mdState_t         r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_isDiv;
   logic             r_divZero;
   logic [WIDTH-1:0] r_aRaw;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_ready;
   logic             r_dzOut;
`ifdef MIPS16_MD_SIGNED_EN
   logic             r_negQ;
   logic             r_negR;
   logic             w_isSigned;
`endif

   logic             w_isDiv;
   logic [WIDTH-1:0] w_aMag;
   logic [WIDTH-1:0] w_bMag;
   logic [WIDTH-1:0] w_accNext;
   logic [WIDTH-1:0] w_qNext;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_hiNext;
   logic [WIDTH-1:0] w_loNext;

   mips16_md_step #(.W(WIDTH)) u_step (
      .i_isDiv (r_isDiv),
      .i_acc   (r_acc),
      .i_q     (r_q),
      .i_m     (r_m),
      .o_acc   (w_accNext),
      .o_q     (w_qNext)
   );

   // Operand conditioning at issue: the datapath always works on magnitudes.
   always_comb begin
      w_isDiv = (op == MD_DIV) || (op == MD_DIVU);
`ifdef MIPS16_MD_SIGNED_EN
      w_isSigned = (op == MD_MULT) || (op == MD_DIV);
      w_aMag     = w_isSigned ? mdMagnitude(a) : a;
      w_bMag     = w_isSigned ? mdMagnitude(b) : b;
`else
      w_aMag     = a;
      w_bMag     = b;
`endif
   end

   // Final result selection: sign fix of the raw magnitudes, then the
   // divide-by-zero override (LO all ones, HI the original dividend).
   always_comb begin
      w_prod = {r_acc, r_q};
      w_quot = r_q;
      w_rem  = r_acc;
`ifdef MIPS16_MD_SIGNED_EN
      if (r_negQ) begin
         w_prod = '0 - {r_acc, r_q};
         w_quot = '0 - r_q;
      end
      if (r_negR) begin
         w_rem = '0 - r_acc;
      end
`endif
      if (!r_isDiv) begin
         w_hiNext = w_prod[2*WIDTH-1:WIDTH];
         w_loNext = w_prod[WIDTH-1:0];
      end else if (r_divZero) begin
         w_hiNext = r_aRaw;
         w_loNext = '1;
      end else begin
         w_hiNext = w_rem;
         w_loNext = w_quot;
      end
   end

   // Sequencer: IDLE accepts a new op (never in the ready cycle), RUN does
   // one iteration per clock, DONE commits HI/LO and pulses ready.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= MD_IDLE;
         r_cnt     <= '0;
         r_isDiv   <= 1'b0;
         r_divZero <= 1'b0;
         r_aRaw    <= '0;
         r_acc     <= '0;
         r_q       <= '0;
         r_m       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b0;
         r_dzOut   <= 1'b0;
`ifdef MIPS16_MD_SIGNED_EN
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
`endif
      end else begin
         r_ready <= 1'b0;
         r_dzOut <= 1'b0;
         case (r_state)
            MD_IDLE: begin
               if (start && !r_ready) begin
                  r_isDiv   <= w_isDiv;
                  r_divZero <= w_isDiv && (b == '0);
                  r_aRaw    <= a;
                  r_acc     <= '0;
                  r_q       <= w_aMag;
                  r_m       <= w_bMag;
                  r_cnt     <= CNT_W'(MD_ITER - 1);
                  r_busy    <= 1'b1;
`ifdef MIPS16_MD_SIGNED_EN
                  r_negQ    <= w_isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_negR    <= w_isSigned && w_isDiv && a[WIDTH-1];
`endif
                  r_state   <= MD_RUN;
               end
            end
            MD_RUN: begin
               r_acc <= w_accNext;
               r_q   <= w_qNext;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == '0) begin
                  r_state <= MD_DONE;
               end
            end
            MD_DONE: begin
               r_hi    <= w_hiNext;
               r_lo    <= w_loNext;
               r_ready <= 1'b1;
               r_dzOut <= r_divZero;
               r_busy  <= 1'b0;
               r_state <= MD_IDLE;
            end
            default: begin
               r_state <= MD_IDLE;
            end
         endcase
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign busy     = r_busy;
   assign ready    = r_ready;
   assign div_zero = r_dzOut;
   assign out      = hi_lo_sl ? r_hi : r_lo;
   assign stall    = r_busy | (start & ~r_ready);

endmodule

// File: tb/tb_mips16_mult_div.sv
// Self-checking bench for mips16_mult_div. A transaction-level model computes
// HI/LO with plain integer arithmetic and predicts busy/ready timing from
// the 17-edge completion latency; a compare process checks every cycle.
// Honours MIPS16_MD_SIGNED_EN the same way as the design.
module tb_mips16_mult_div;

   logic        clock    = 1'b0;
   logic        reset_n  = 1'b1;
   logic        start    = 1'b0;
   logic [1:0]  op       = 2'b00;
   logic [15:0] a        = 16'h0;
   logic [15:0] b        = 16'h0;
   logic        hi_lo_sl = 1'b0;
   logic [15:0] out;
   logic [15:0] hi;
   logic [15:0] lo;
   logic        busy;
   logic        ready;
   logic        stall;
   logic        div_zero;

   int nCompared   = 0;
   int nMismatched = 0;
   int readyCount  = 0;
   int cyc         = 0;
   bit cmpEn       = 1'b0;

   bit          mPending   = 1'b0;
   bit          mReady     = 1'b0;
   bit          mDz        = 1'b0;
   bit          mPrevReady = 1'b0;
   bit          mResDz     = 1'b0;
   logic [15:0] mHi        = 16'h0;
   logic [15:0] mLo        = 16'h0;
   logic [15:0] mResHi     = 16'h0;
   logic [15:0] mResLo     = 16'h0;
   int          mDoneAt    = 0;

   mips16_mult_div #(.WIDTH(16)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi_lo_sl (hi_lo_sl),
      .out      (out),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .ready    (ready),
      .stall    (stall),
      .div_zero (div_zero)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Arithmetic reference: what HI/LO must hold after an op, from the
   // instruction semantics alone.
   function automatic void mdModel(input logic [1:0] o, input logic [15:0] x,
                                   input logic [15:0] y, output logic [15:0] h,
                                   output logic [15:0] l, output bit dz);
      longint sx, sy, p, q, r;
      bit sgn;
`ifdef MIPS16_MD_SIGNED_EN
      sgn = (o == 2'b00) || (o == 2'b10);
`else
      sgn = 1'b0;
`endif
      sx = sgn ? longint'($signed(x)) : longint'(x);
      sy = sgn ? longint'($signed(y)) : longint'(y);
      dz = 1'b0;
      if (!o[1]) begin
         p = sx * sy;
         h = p[31:16];
         l = p[15:0];
      end else if (y == 16'h0) begin
         h  = x;
         l  = 16'hFFFF;
         dz = 1'b1;
      end else begin
         q = sx / sy;
         r = sx % sy;
         h = r[15:0];
         l = q[15:0];
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Transaction model: accept when idle and not in the ready cycle,
   // complete 17 edges later; reset drops everything.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mPending = 1'b0;
         mReady   = 1'b0;
         mDz      = 1'b0;
         mHi      = 16'h0;
         mLo      = 16'h0;
      end else begin
         cyc++;
         mPrevReady = mReady;
         mReady     = 1'b0;
         mDz        = 1'b0;
         if (mPending && cyc == mDoneAt) begin
            mHi      = mResHi;
            mLo      = mResLo;
            mDz      = mResDz;
            mReady   = 1'b1;
            mPending = 1'b0;
         end else if (!mPending && start && !mPrevReady) begin
            mdModel(op, a, b, mResHi, mResLo, mResDz);
            mPending = 1'b1;
            mDoneAt  = cyc + 17;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clock) begin
      if (cmpEn) begin
         checkOutput("busy", busy, mPending);
         checkOutput("ready", ready, mReady);
         checkOutput("div_zero", div_zero, mDz);
         checkOutput("hi", hi, mHi);
         checkOutput("lo", lo, mLo);
         checkOutput("out", out, hi_lo_sl ? mHi : mLo);
         checkOutput("stall", stall, mPending | (start & ~mReady));
      end
      if (ready) readyCount++;
   end

   // Issue one op, scramble operands after the accept edge, optionally poke
   // start mid-run, and measure latency and stall length up to ready.
   task automatic applyStimulus(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                input bit intrude, output int lat, output int stallCnt);
      @(posedge clock); #1;
      start = 1'b1; op = o; a = x; b = y;
      hi_lo_sl = 1'($urandom_range(0, 1));
      stallCnt = 0;
      lat = 0;
      @(negedge clock);
      if (stall) stallCnt++;
      @(posedge clock); #1;
      start = 1'b0;
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 2'($urandom_range(0, 3));
      while (lat < 40) begin
         @(negedge clock);
         lat++;
         if (stall) stallCnt++;
         if (ready) break;
         @(posedge clock); #1;
         hi_lo_sl = 1'($urandom_range(0, 1));
         if (intrude && lat == 5) begin
            start = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      if (!ready) checkOutput("readyTimeout", ready, 1);
   endtask

   // Directed op with hand-computed results, including HI/LO on out.
   task automatic runDirected(input string name, input logic [1:0] o, input logic [15:0] x,
                              input logic [15:0] y, input logic [15:0] eHi,
                              input logic [15:0] eLo, input bit eDz);
      int lat, sc;
      applyStimulus(o, x, y, 1'b0, lat, sc);
      checkOutput({name, ".latency"}, lat, 18);
      checkOutput({name, ".stallCycles"}, sc, 18);
      checkOutput({name, ".hi"}, hi, eHi);
      checkOutput({name, ".lo"}, lo, eLo);
      checkOutput({name, ".divZero"}, div_zero, eDz);
      #1 hi_lo_sl = 1'b1;
      #1 checkOutput({name, ".outHi"}, out, eHi);
      hi_lo_sl = 1'b0;
      #1 checkOutput({name, ".outLo"}, out, eLo);
   endtask

   // Bound on total run time.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rc0, n, lat, sc;
      logic [1:0]  ro;
      logic [15:0] ra, rb;

      #2 reset_n = 1'b0;
      cmpEn = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst.hi", hi, 16'h0);
      checkOutput("rst.lo", lo, 16'h0);
      checkOutput("rst.out", out, 16'h0);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.ready", ready, 0);
      checkOutput("rst.divZero", div_zero, 0);
      reset_n = 1'b1;

      $display("[TB] directed operations");
      runDirected("multu3x5", 2'b01, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0);
      runDirected("multuMax", 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
      runDirected("divu100by7", 2'b11, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0);
      runDirected("divuByZero", 2'b11, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
      @(posedge clock); #1;
      checkOutput("divZeroOnePulse", div_zero, 0);
`ifdef MIPS16_MD_SIGNED_EN
      runDirected("multNeg", 2'b00, 16'hFFFE, 16'h0003, 16'hFFFF, 16'hFFFA, 1'b0);
      runDirected("divNeg", 2'b10, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0);
      runDirected("divOverflow", 2'b10, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
      runDirected("divNegByZero", 2'b10, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1);
`else
      runDirected("multAsUnsigned", 2'b00, 16'hFFFE, 16'h0003, 16'h0002, 16'hFFFA, 1'b0);
      runDirected("divAsUnsigned", 2'b10, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0);
`endif

      $display("[TB] reset during a multiply");
      @(posedge clock); #1;
      start = 1'b1; op = 2'b01; a = 16'h1234; b = 16'h5678;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (7) @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("abort.busy", busy, 0);
      checkOutput("abort.hi", hi, 16'h0);
      checkOutput("abort.lo", lo, 16'h0);
      checkOutput("abort.ready", ready, 0);
      @(posedge clock); #1 reset_n = 1'b1;
      rc0 = readyCount;
      repeat (25) @(negedge clock);
      #1 checkOutput("abort.noReady", readyCount - rc0, 0);
      runDirected("multu2x2", 2'b01, 16'h0002, 16'h0002, 16'h0000, 16'h0004, 1'b0);

      $display("[TB] start held through the ready cycle");
      rc0 = readyCount;
      @(posedge clock); #1;
      start = 1'b1; op = 2'b01; a = 16'h0007; b = 16'h0009;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!ready && n < 40);
      checkOutput("held.ready", ready, 1);
      checkOutput("held.lo", lo, 16'h003F);
      checkOutput("held.hi", hi, 16'h0000);
      @(posedge clock); #1;
      start = 1'b0;
      repeat (20) @(negedge clock);
      #1;
      checkOutput("held.oneCompletion", readyCount - rc0, 1);
      checkOutput("held.noRestart", busy, 0);
      runDirected("multuAfterHeld", 2'b01, 16'h0010, 16'h0011, 16'h0000, 16'h0110, 1'b0);
      #1 checkOutput("held.twoCompletions", readyCount - rc0, 2);

      $display("[TB] randomized operations");
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = 16'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 16'h0000;
            1: begin ra = 16'h8000; rb = 16'hFFFF; end
            2: rb = 16'($urandom_range(1, 15));
            default: rb = 16'($urandom);
         endcase
         applyStimulus(ro, ra, rb, (i % 3) == 0, lat, sc);
         checkOutput("rand.latency", lat, 18);
         checkOutput("rand.stallCycles", sc, 18);
      end

      repeat (3) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
